// File: rtl/mem_access_stage.sv
// MEM pipeline stage: drives the data-memory port, holds strobes for MemLatency wait cycles
// while stalling upstream, and registers the writeback payload. Optional macro: MEM_STATS_EN.
module mem_access_stage #(
   parameter int DataWidth   = 16,
   parameter int RegAddrBits = 3,
   parameter int MemLatency  = 2
) (
   input  logic                   CLK,
   input  logic                   RST,
`ifdef MEM_STATS_EN
   output logic [15:0]            stall_count,
`endif
   input  logic                   ex_valid,
   input  logic                   ex_mem_read,
   input  logic                   ex_mem_write,
   input  logic                   ex_reg_write,
   input  logic [DataWidth-1:0]   ex_alu_result,
   input  logic [DataWidth-1:0]   ex_store_data,
   input  logic [RegAddrBits-1:0] ex_dest,
   output logic                   stall,
   output logic                   MemRead,
   output logic                   MemWrite,
   output logic [DataWidth-1:0]   MemAddr,
   output logic [DataWidth-1:0]   MemData,
   input  logic [DataWidth-1:0]   MemOutput,
   output logic                   wb_valid,
   output logic                   wb_reg_write,
   output logic [RegAddrBits-1:0] wb_dest,
   output logic [DataWidth-1:0]   wb_data
);

   typedef enum logic {IDLE, ACCESS} stateType;

   localparam logic [3:0] LastCount = 4'(MemLatency - 1);

   stateType               state;
   logic [3:0]             count;
   logic                   pendLoad;
   logic                   pendRegWrite;
   logic [RegAddrBits-1:0] pendDest;

   assign stall = (state == ACCESS);

   // NOTE: every register here is state, so only non-blocking assignments are used;
   // each branch assigns only what changes, the rest holds by flop behaviour (no latches).
   always_ff @(posedge CLK) begin
      if (RST) begin
         state        <= IDLE;
         count        <= '0;
         pendLoad     <= 1'b0;
         pendRegWrite <= 1'b0;
         pendDest     <= '0;
         MemRead      <= 1'b0;
         MemWrite     <= 1'b0;
         MemAddr      <= '0;
         MemData      <= '0;
         wb_valid     <= 1'b0;
         wb_reg_write <= 1'b0;
         wb_dest      <= '0;
         wb_data      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (!ex_valid) begin
                  wb_valid     <= 1'b0;
                  wb_reg_write <= 1'b0;
               end else if (ex_mem_read || ex_mem_write) begin
                  state    <= ACCESS;
                  count    <= '0;
                  MemAddr  <= ex_alu_result;
                  wb_valid <= 1'b0;
                  // A simultaneous read+write request is serviced as a store.
                  if (ex_mem_write) begin
                     MemWrite <= 1'b1;
                     MemData  <= ex_store_data;
                  end else begin
                     MemRead <= 1'b1;
                  end
                  pendLoad     <= !ex_mem_write;
                  pendRegWrite <= ex_reg_write && !ex_mem_write;
                  pendDest     <= ex_dest;
               end else begin
                  wb_valid     <= 1'b1;
                  wb_reg_write <= ex_reg_write;
                  wb_dest      <= ex_dest;
                  wb_data      <= ex_alu_result;
               end
            end
            ACCESS: begin
               if (count == LastCount) begin
                  state    <= IDLE;
                  count    <= '0;
                  MemRead  <= 1'b0;
                  MemWrite <= 1'b0;
                  MemAddr  <= '0;
                  MemData  <= '0;
                  wb_valid <= 1'b1;
                  wb_dest  <= pendDest;
                  if (pendLoad) begin
                     wb_data      <= MemOutput;
                     wb_reg_write <= pendRegWrite;
                  end else begin
                     wb_reg_write <= 1'b0;
                  end
               end else begin
                  count <= count + 4'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef MEM_STATS_EN
   always_ff @(posedge CLK) begin
      if (RST)
         stall_count <= '0;
      else if (stall && stall_count != 16'hFFFF)
         stall_count <= stall_count + 16'd1;
   end
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed scenarios plus a randomized instruction
// stream checked against a transaction-level model of the stage.
module tb_mem_access_stage;

   localparam int Lat = 2;

   logic        CLK = 1'b0;
   logic        RST;
   logic        ex_valid, ex_mem_read, ex_mem_write, ex_reg_write;
   logic [15:0] ex_alu_result, ex_store_data;
   logic [2:0]  ex_dest;
   logic        stall, MemRead, MemWrite;
   logic [15:0] MemAddr, MemData, MemOutput;
   logic        wb_valid, wb_reg_write;
   logic [2:0]  wb_dest;
   logic [15:0] wb_data;
`ifdef MEM_STATS_EN
   logic [15:0] stall_count;
`endif

   int total = 0;
   int bad   = 0;

   // Model state: last registered writeback payload and expected stall-cycle total.
   logic [15:0] expData;
   logic [2:0]  expDest;
   int          expStalls;

   mem_access_stage #(.DataWidth(16), .RegAddrBits(3), .MemLatency(Lat)) dut (
      .CLK(CLK), .RST(RST),
`ifdef MEM_STATS_EN
      .stall_count(stall_count),
`endif
      .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
      .ex_reg_write(ex_reg_write), .ex_alu_result(ex_alu_result),
      .ex_store_data(ex_store_data), .ex_dest(ex_dest),
      .stall(stall), .MemRead(MemRead), .MemWrite(MemWrite),
      .MemAddr(MemAddr), .MemData(MemData), .MemOutput(MemOutput),
      .wb_valid(wb_valid), .wb_reg_write(wb_reg_write),
      .wb_dest(wb_dest), .wb_data(wb_data)
   );

   always #5 CLK = ~CLK;

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   task automatic scramble_ex;
      ex_valid      = 1'($urandom);
      ex_mem_read   = 1'($urandom);
      ex_mem_write  = 1'($urandom);
      ex_reg_write  = 1'($urandom);
      ex_alu_result = 16'($urandom);
      ex_store_data = 16'($urandom);
      ex_dest       = 3'($urandom);
   endtask

   // Issues one instruction and follows it to its writeback, comparing every cycle.
   task automatic run_instr(input logic rd, input logic wr, input logic rw,
                            input logic [15:0] alu, input logic [15:0] st,
                            input logic [2:0] dest, input logic [15:0] memVal,
                            input bit scramble, input string tag);
      logic [35:0] accGot, accExp;
      logic [55:0] got, exp;
      logic        isStore;
      ex_valid = 1'b1; ex_mem_read = rd; ex_mem_write = wr; ex_reg_write = rw;
      ex_alu_result = alu; ex_store_data = st; ex_dest = dest;
      tick;
      isStore = wr;
      if (rd || wr) begin
         for (int i = 0; i < Lat; i++) begin
            accGot = {stall, MemRead, MemWrite, MemAddr, MemData, wb_valid};
            accExp = {1'b1, !isStore, isStore, alu, isStore ? st : 16'h0000, 1'b0};
            total++;
            if (accGot !== accExp) begin
               bad++;
               $display("FAIL %s access cycle %0d: got %h expected %h", tag, i, accGot, accExp);
            end
            MemOutput = (i == Lat - 1) ? memVal : 16'($urandom);
            if (scramble) scramble_ex();
            tick;
         end
         expStalls += Lat;
         if (!isStore) expData = memVal;
         expDest = dest;
         exp = {1'b1, isStore ? 1'b0 : rw, expDest, expData, 3'b000, 32'h0};
      end else begin
         expData = alu;
         expDest = dest;
         exp = {1'b1, rw, expDest, expData, 3'b000, 32'h0};
      end
      got = {wb_valid, wb_reg_write, wb_dest, wb_data, stall, MemRead, MemWrite, MemAddr, MemData};
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s writeback: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic run_bubble(input string tag);
      logic [55:0] got, exp;
      scramble_ex();
      ex_valid = 1'b0;
      tick;
      got = {wb_valid, wb_reg_write, wb_dest, wb_data, stall, MemRead, MemWrite, MemAddr, MemData};
      exp = {1'b0, 1'b0, expDest, expData, 3'b000, 32'h0};
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s bubble: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic check_stats(input string tag);
`ifdef MEM_STATS_EN
      total++;
      if (stall_count !== 16'(expStalls)) begin
         bad++;
         $display("FAIL %s stall_count: got %0d expected %0d", tag, stall_count, expStalls);
      end
`else
      if (tag.len() < 0) $display("%s", tag);
`endif
   endtask

   task automatic test_reset;
      logic [55:0] got;
      scramble_ex();
      MemOutput = 16'($urandom);
      RST = 1'b1;
      tick;
      tick;
      RST = 1'b0;
      ex_valid = 1'b0;
      expData = '0; expDest = '0; expStalls = 0;
      got = {wb_valid, wb_reg_write, wb_dest, wb_data, stall, MemRead, MemWrite, MemAddr, MemData};
      total++;
      if (got !== 56'h0) begin
         bad++;
         $display("FAIL reset outputs: got %h expected 0", got);
      end
      check_stats("reset");
   endtask

   task automatic test_alu;
      run_instr(1'b0, 1'b0, 1'b1, 16'h0014, 16'h0000, 3'd5, 16'h0000, 1'b0, "alu");
      run_bubble("alu_after");
   endtask

   task automatic test_reset_during_access;
      logic [1:0]  acc;
      logic [55:0] got;
      ex_valid = 1'b1; ex_mem_read = 1'b1; ex_mem_write = 1'b0; ex_reg_write = 1'b1;
      ex_alu_result = 16'h0020; ex_store_data = 16'h0000; ex_dest = 3'd3;
      tick;
      acc = {stall, MemRead};
      total++;
      if (acc !== 2'b11) begin
         bad++;
         $display("FAIL rst_access entry: got %b expected 11", acc);
      end
      MemOutput = 16'hDEAD;
      RST = 1'b1;
      tick;
      RST = 1'b0;
      ex_valid = 1'b0;
      expData = '0; expDest = '0; expStalls = 0;
      got = {wb_valid, wb_reg_write, wb_dest, wb_data, stall, MemRead, MemWrite, MemAddr, MemData};
      total++;
      if (got !== 56'h0) begin
         bad++;
         $display("FAIL rst_access abandon: got %h expected 0", got);
      end
      for (int i = 0; i < Lat + 2; i++) run_bubble("rst_access_after");
      check_stats("rst_access");
   endtask

   task automatic test_load;
      run_instr(1'b1, 1'b0, 1'b1, 16'h0020, 16'h5555, 3'd3, 16'hBEEF, 1'b0, "load");
   endtask

   task automatic test_store;
      run_instr(1'b0, 1'b1, 1'b1, 16'h0010, 16'h1234, 3'd1, 16'hAAAA, 1'b0, "store");
   endtask

   task automatic test_load_then_alu;
      logic [35:0] accGot, accExp;
      logic [55:0] got, exp;
      ex_valid = 1'b1; ex_mem_read = 1'b1; ex_mem_write = 1'b0; ex_reg_write = 1'b1;
      ex_alu_result = 16'h0030; ex_store_data = 16'h0000; ex_dest = 3'd2;
      tick;
      // The following ALU op waits in EX/MEM while the load occupies the port.
      ex_mem_read = 1'b0; ex_alu_result = 16'h0015; ex_dest = 3'd4;
      for (int i = 0; i < Lat; i++) begin
         accGot = {stall, MemRead, MemWrite, MemAddr, MemData, wb_valid};
         accExp = {1'b1, 1'b1, 1'b0, 16'h0030, 16'h0000, 1'b0};
         total++;
         if (accGot !== accExp) begin
            bad++;
            $display("FAIL ld_alu access %0d: got %h expected %h", i, accGot, accExp);
         end
         MemOutput = (i == Lat - 1) ? 16'hCAFE : 16'h0BAD;
         tick;
      end
      expStalls += Lat;
      got = {wb_valid, wb_reg_write, wb_dest, wb_data, stall, MemRead, MemWrite, MemAddr, MemData};
      exp = {1'b1, 1'b1, 3'd2, 16'hCAFE, 3'b000, 32'h0};
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL ld_alu load wb: got %h expected %h", got, exp);
      end
      tick;
      expData = 16'h0015; expDest = 3'd4;
      got = {wb_valid, wb_reg_write, wb_dest, wb_data, stall, MemRead, MemWrite, MemAddr, MemData};
      exp = {1'b1, 1'b1, 3'd4, 16'h0015, 3'b000, 32'h0};
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL ld_alu alu wb: got %h expected %h", got, exp);
      end
      run_bubble("ld_alu_no_dup");
   endtask

   task automatic test_read_write_both;
      run_instr(1'b1, 1'b1, 1'b1, 16'h0008, 16'h00FF, 3'd6, 16'h7777, 1'b0, "rdwr");
   endtask

   task automatic test_stats_total;
`ifdef MEM_STATS_EN
      total++;
      if (stall_count !== 16'd8) begin
         bad++;
         $display("FAIL stats_total: got %0d expected 8", stall_count);
      end
`endif
      check_stats("stats_model");
   endtask

   task automatic test_random;
      int kind;
      for (int n = 0; n < 300; n++) begin
         kind = $urandom_range(0, 9);
         case (kind)
            0, 1:    run_bubble("rand");
            2, 3, 4: run_instr(1'b0, 1'b0, 1'($urandom), 16'($urandom), 16'($urandom),
                               3'($urandom), 16'($urandom), 1'b1, "rand_alu");
            5, 6:    run_instr(1'b1, 1'b0, 1'($urandom), 16'($urandom), 16'($urandom),
                               3'($urandom), 16'($urandom), 1'b1, "rand_load");
            7, 8:    run_instr(1'b0, 1'b1, 1'($urandom), 16'($urandom), 16'($urandom),
                               3'($urandom), 16'($urandom), 1'b1, "rand_store");
            default: run_instr(1'b1, 1'b1, 1'($urandom), 16'($urandom), 16'($urandom),
                               3'($urandom), 16'($urandom), 1'b1, "rand_rdwr");
         endcase
      end
      check_stats("rand");
   endtask

   initial begin
      RST = 1'b1;
      MemOutput = '0;
      ex_valid = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0; ex_reg_write = 1'b0;
      ex_alu_result = '0; ex_store_data = '0; ex_dest = '0;
      expData = '0; expDest = '0; expStalls = 0;
      test_reset();
      test_alu();
      test_reset_during_access();
      test_load();
      test_store();
      test_load_then_alu();
      test_read_write_both();
      test_stats_total();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete within time limit");
      $fatal(1, "timeout");
   end

endmodule
